// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame from a circular FIFO and
// serialises it as start, 8 data bits LSB first, optional even parity, stop.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       En,
   input  logic       Empty,
   input  logic [7:0] Fifo_IO,
   output logic       Fifo_E,
   output logic       Fifo_RW,
   output logic       Fifo_RW1,
   output logic       Tx,
   output logic       Busy,
   output logic       Tx_done
);

   typedef enum logic [2:0] {S_IDLE, S_POP, S_START, S_DATA, S_PAR, S_STOP} state_t;

   localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);

   state_t     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] sh_q, sh_d;
   logic       par_q, par_d;
   logic       bit_end;

   assign bit_end = (cnt_q == LAST);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
      end
   end

   // Counter wraps to 0 at each bit end, which is also every state entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? 10'd0 : cnt_q + 10'd1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      par_d   = par_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (En && !Empty) state_d = S_POP;
         end
         S_POP: begin
            cnt_d   = '0;
            sh_d    = Fifo_IO;
            par_d   = ^Fifo_IO;
            state_d = S_START;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               sh_d  = {1'b0, sh_q[7:1]};
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
         end
         S_PAR: begin
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_end) state_d = (En && !Empty) ? S_POP : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Tx       = 1'b1;
      Busy     = 1'b1;
      Tx_done  = 1'b0;
      Fifo_E   = 1'b0;
      Fifo_RW  = 1'b1;
      Fifo_RW1 = 1'b0;
      case (state_q)
         S_IDLE:  Busy = 1'b0;
         S_POP: begin
            Fifo_E   = 1'b1;
            Fifo_RW  = 1'b0;
            Fifo_RW1 = 1'b1;
         end
         S_START: Tx = 1'b0;
         S_DATA:  Tx = sh_q[0];
         S_PAR:   Tx = par_q;
         S_STOP:  Tx_done = bit_end;
         default: Busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: two DUTs (CPB=4 no parity, CPB=3 even parity) each fed by a
// 32-entry circular FIFO model; a serial-line decoder checks every frame.
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] en, empty, fe, rw, rw1, tx, busy, done;
   logic [7:0] fio [2];

   logic [7:0] mem [2][32];
   logic [5:0] wr [2] = '{6'd0, 6'd0};
   logic [5:0] rd [2] = '{6'd0, 6'd0};
   logic [7:0] exp_q [2][$];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign empty[0] = (wr[0] == rd[0]);
   assign empty[1] = (wr[1] == rd[1]);
   assign fio[0]   = mem[0][rd[0][4:0]];
   assign fio[1]   = mem[1][rd[1][4:0]];

   fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0)) u0 (
      .Clk(clk), .Rst_n(rst_n), .En(en[0]), .Empty(empty[0]), .Fifo_IO(fio[0]),
      .Fifo_E(fe[0]), .Fifo_RW(rw[0]), .Fifo_RW1(rw1[0]), .Tx(tx[0]),
      .Busy(busy[0]), .Tx_done(done[0]));

   fifo_uart_tx #(.CLKS_PER_BIT(3), .PARITY(1)) u1 (
      .Clk(clk), .Rst_n(rst_n), .En(en[1]), .Empty(empty[1]), .Fifo_IO(fio[1]),
      .Fifo_E(fe[1]), .Fifo_RW(rw[1]), .Fifo_RW1(rw1[1]), .Tx(tx[1]),
      .Busy(busy[1]), .Tx_done(done[1]));

   // FIFO front pointer advances on the edge that ends a read strobe.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         if (fe[d] && !rw[d]) rd[d] <= rd[d] + 6'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++)
         if (fe[d] === 1'b1) check($sformatf("pop_while_empty%0d", d), {31'd0, empty[d]}, 32'd0);
   end

   task automatic push(input int d, input logic [7:0] b);
      mem[d][wr[d][4:0]] = b;
      wr[d] = wr[d] + 6'd1;
      exp_q[d].push_back(b);
   endtask

   function automatic logic fbit(input int d, input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (d == 1 && i == 9) return 1'(($countones(b)) % 2);
      return 1'b1;
   endfunction

   // Waits for the start bit, then checks every cycle of the frame.
   task automatic recv(input int d, input int gap_exp, input int drop_bit);
      int n, cpb, nb;
      logic [7:0] b;
      logic obs, e;
      bit dbad, sbad;
      cpb = (d == 1) ? 3 : 4;
      nb  = (d == 1) ? 11 : 10;
      b = (exp_q[d].size() > 0) ? exp_q[d].pop_front() : 8'h00;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx[d] !== 1'b0 && n < 2000);
      check($sformatf("start_seen%0d", d), {31'd0, tx[d]}, 32'd0);
      if (tx[d] !== 1'b0) return;
      if (gap_exp >= 0) check($sformatf("gap%0d", d), n, gap_exp);
      dbad = 0;
      sbad = 0;
      for (int i = 0; i < nb; i++) begin
         e = fbit(d, b, i);
         obs = e;
         for (int c = 0; c < cpb; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (i == drop_bit && c == 0) en[d] = 1'b0;
            if (tx[d] !== e) obs = tx[d];
            if (done[d] !== ((i == nb-1) && (c == cpb-1))) dbad = 1;
            if (busy[d] !== 1'b1 || fe[d] !== 1'b0 || rw[d] !== 1'b1 || rw1[d] !== 1'b0) sbad = 1;
         end
         check($sformatf("d%0d byte%02h bit%0d", d, b, i), {31'd0, obs}, {31'd0, e});
      end
      check($sformatf("tx_done_pulse%0d", d), {31'd0, dbad}, 32'd0);
      check($sformatf("busy_strobes_in_frame%0d", d), {31'd0, sbad}, 32'd0);
   endtask

   task automatic expect_pop(input int d);
      @(negedge clk);
      check("pop_fe",  {31'd0, fe[d]},   32'd1);
      check("pop_rw",  {31'd0, rw[d]},   32'd0);
      check("pop_rw1", {31'd0, rw1[d]},  32'd1);
      check("pop_busy",{31'd0, busy[d]}, 32'd1);
   endtask

   task automatic expect_idle(input int d);
      @(negedge clk);
      check("idle_busy", {31'd0, busy[d]}, 32'd0);
      check("idle_fe",   {31'd0, fe[d]},   32'd0);
      check("idle_tx",   {31'd0, tx[d]},   32'd1);
   endtask

   initial begin
      logic [5:0] rd_snap;
      rst_n = 1'b0;
      en = 2'b11;
      push(0, 8'hA5);
      repeat (3) @(negedge clk);
      check("rst_tx",   {31'd0, tx[0]},   32'd1);
      check("rst_busy", {31'd0, busy[0]}, 32'd0);
      check("rst_done", {31'd0, done[0]}, 32'd0);
      check("rst_fe",   {31'd0, fe[0]},   32'd0);
      check("rst_rw",   {31'd0, rw[0]},   32'd1);
      check("rst_rw1",  {31'd0, rw1[0]},  32'd0);
      check("rst_tx1",  {31'd0, tx[1]},   32'd1);
      rst_n = 1'b1;
      expect_pop(0);
      recv(0, 1, -1);
      expect_idle(0);
      check("single_pop_count", {26'd0, rd[0]}, 32'd1);

      // Even parity: 07 -> 1, 03 -> 0, then random bytes
      push(1, 8'h07);
      push(1, 8'h03);
      for (int k = 0; k < 4; k++) push(1, 8'($urandom));
      for (int k = 0; k < 6; k++) recv(1, 2, -1);
      expect_idle(1);

      // Streaming 33 bytes through a 32-deep FIFO that wraps
      for (int k = 0; k < 32; k++) push(0, 8'(k));
      recv(0, 2, -1);
      push(0, 8'd32);
      for (int k = 1; k < 33; k++) recv(0, 2, -1);
      expect_idle(0);
      check("stream_pop_count", {26'd0, rd[0]}, 32'd34);

      // En dropped during DATA of frame 1
      for (int k = 0; k < 3; k++) push(0, 8'($urandom));
      recv(0, 2, 3);
      expect_idle(0);
      rd_snap = rd[0];
      repeat (10) @(negedge clk);
      check("en_drop_no_pop", {26'd0, rd[0]}, {26'd0, rd_snap});
      check("en_drop_busy", {31'd0, busy[0]}, 32'd0);
      en[0] = 1'b1;
      expect_pop(0);
      recv(0, 1, -1);
      recv(0, 2, -1);
      expect_idle(0);

      // Reset during frame bit 4: interrupted byte is lost
      push(0, 8'($urandom));
      push(0, 8'($urandom));
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (tx[0] !== 1'b0 && n < 2000);
         check("rst_mid_start", {31'd0, tx[0]}, 32'd0);
      end
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx",   {31'd0, tx[0]},   32'd1);
      check("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
      check("rst_mid_done", {31'd0, done[0]}, 32'd0);
      void'(exp_q[0].pop_front());
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      expect_pop(0);
      recv(0, 1, -1);
      expect_idle(0);
      check("final_empty", {31'd0, empty[0]}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
